// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between an instruction-fetch and a data requester.
// Grant -> m_valid next cycle, ack one cycle after m_ready; m_ready timeout after MAX_WAIT cycles sets sticky err.
module mem_arbiter #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        m_valid,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ready,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    localparam logic [7:0] MAX_WAIT_C = MAX_WAIT[7:0];

    state_t      state_q, state_d;
    logic        last_d_q, last_d_d;
    logic        gnt_d_q, gnt_d_d;
    logic        m_valid_q, m_valid_d;
    logic        m_we_q, m_we_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic        i_ack_q, i_ack_d;
    logic        d_ack_q, d_ack_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        err_q, err_d;
    logic [7:0]  wait_q, wait_d;
    logic        pick_d;
    logic        finish;
    logic        timeout;
    logic [31:0] ack_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            last_d_q  <= 1'b1;
            gnt_d_q   <= 1'b0;
            m_valid_q <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            err_q     <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            last_d_q  <= last_d_d;
            gnt_d_q   <= gnt_d_d;
            m_valid_q <= m_valid_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            err_q     <= err_d;
            wait_q    <= wait_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d_d  = last_d_q;
        gnt_d_d   = gnt_d_q;
        m_valid_d = m_valid_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        i_rdata_d = '0;
        d_rdata_d = '0;
        err_d     = err_q;
        wait_d    = wait_q;
        // On a tie, D wins only if I was granted last.
        pick_d    = d_req && (!i_req || !last_d_q);
        // Timeout fires on the MAX_WAIT-th low-ready cycle, so m_valid is high exactly MAX_WAIT cycles.
        timeout   = !m_ready && ((wait_q + 8'd1) == MAX_WAIT_C);
        finish    = m_ready || timeout;
        ack_data  = (m_ready && !m_we_q) ? m_rdata : 32'd0;

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    state_d   = BUSY;
                    gnt_d_d   = pick_d;
                    last_d_d  = pick_d;
                    m_valid_d = 1'b1;
                    m_we_d    = pick_d && d_we;
                    m_addr_d  = pick_d ? d_addr : i_addr;
                    m_wdata_d = pick_d ? d_wdata : 32'd0;
                    wait_d    = '0;
                end
            end
            BUSY: begin
                if (!m_ready) begin
                    wait_d = wait_q + 8'd1;
                end
                if (finish) begin
                    state_d   = ACK;
                    m_valid_d = 1'b0;
                    if (timeout) begin
                        err_d = 1'b1;
                    end
                    if (gnt_d_q) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = ack_data;
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = ack_data;
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign i_rdata = i_rdata_q;
    assign i_ack   = i_ack_q;
    assign d_rdata = d_rdata_q;
    assign d_ack   = d_ack_q;
    assign m_valid = m_valid_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign err     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: default instance for the main flows, MAX_WAIT=4 instance for timeout.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req, d_req, d_we, m_ready;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;

    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic        i_ack, d_ack, m_valid, m_we, err;

    logic [31:0] t_i_rdata, t_d_rdata, t_m_addr, t_m_wdata;
    logic        t_i_ack, t_d_ack, t_m_valid, t_m_we, t_err;

    int n_chk;
    int n_err;
    int acks;

    mem_arbiter u_dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready), .err(err)
    );

    mem_arbiter #(.MAX_WAIT(4)) u_dut_to (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(t_i_rdata), .i_ack(t_i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(t_d_rdata), .d_ack(t_d_ack),
        .m_valid(t_m_valid), .m_we(t_m_we), .m_addr(t_m_addr), .m_wdata(t_m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready), .err(t_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        i_req   = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        m_ready = 1'b0;
        i_addr  = '0;
        d_addr  = '0;
        d_wdata = '0;
        m_rdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;

        // Single fetch.
        do_reset();
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        i_req = 1'b1; i_addr = 32'h100; m_ready = 1'b1; m_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("f_m_valid", {31'd0, m_valid}, 32'd1);
        chk("f_m_addr", m_addr, 32'h100);
        chk("f_m_we_wdata", {m_wdata[30:0], m_we}, 32'd0);
        chk("f_no_ack_yet", {31'd0, i_ack}, 32'd0);
        @(negedge clk);
        chk("f_i_ack", {31'd0, i_ack}, 32'd1);
        chk("f_i_rdata", i_rdata, 32'hDEADBEEF);
        chk("f_m_valid_clr", {31'd0, m_valid}, 32'd0);
        chk("f_d_ack", {31'd0, d_ack}, 32'd0);
        i_req = 1'b0;
        @(negedge clk);
        chk("f_i_ack_end", {31'd0, i_ack}, 32'd0);
        chk("f_i_rdata_end", i_rdata, 32'd0);
        repeat (2) @(negedge clk);
        chk("f_no_regrant", {31'd0, m_valid}, 32'd0);

        // Tie from reset: I first, then alternating.
        do_reset();
        i_req = 1'b1; i_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678;
        m_ready = 1'b1; m_rdata = 32'hA5A5A5A5;
        @(negedge clk);
        chk("t1_addr", m_addr, 32'h200);
        chk("t1_we", {31'd0, m_we}, 32'd0);
        @(negedge clk);
        chk("t1_i_ack", {31'd0, i_ack}, 32'd1);
        chk("t1_i_rdata", i_rdata, 32'hA5A5A5A5);
        @(negedge clk);
        chk("t_idle_gap", {31'd0, m_valid}, 32'd0);
        @(negedge clk);
        chk("t2_valid", {31'd0, m_valid}, 32'd1);
        chk("t2_addr", m_addr, 32'h40);
        chk("t2_wdata", m_wdata, 32'h12345678);
        chk("t2_we", {31'd0, m_we}, 32'd1);
        @(negedge clk);
        chk("t2_d_ack", {31'd0, d_ack}, 32'd1);
        chk("t2_d_rdata_wr", d_rdata, 32'd0);
        chk("t2_i_ack", {31'd0, i_ack}, 32'd0);
        repeat (2) @(negedge clk);
        chk("t3_addr_i", m_addr, 32'h200);
        repeat (3) @(negedge clk);
        chk("t4_addr_d", m_addr, 32'h40);

        // Wait states: 5 low-ready cycles then one ready cycle.
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_wdata = 32'h77;
        acks = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("w_valid_%0d", k), {31'd0, m_valid}, 32'd1);
            chk($sformatf("w_addr_%0d", k), m_addr, 32'h80);
            chk($sformatf("w_wdata_%0d", k), m_wdata, 32'h77);
            chk($sformatf("w_we_%0d", k), {31'd0, m_we}, 32'd0);
            acks += int'(d_ack) + int'(i_ack);
            if (k == 6) begin
                m_ready = 1'b1; m_rdata = 32'h0BADF00D;
            end
        end
        @(negedge clk);
        chk("w_d_rdata", d_rdata, 32'h0BADF00D);
        acks += int'(d_ack) + int'(i_ack);
        d_req = 1'b0; m_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            acks += int'(d_ack) + int'(i_ack);
        end
        chk("w_ack_count", acks, 32'd1);
        chk("w_err", {31'd0, err}, 32'd0);

        // Timeout on the MAX_WAIT=4 instance.
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44; m_rdata = 32'hFFFFFFFF;
        repeat (4) @(negedge clk);
        chk("to_valid_c4", {31'd0, t_m_valid}, 32'd1);
        chk("to_err_c4", {31'd0, t_err}, 32'd0);
        @(negedge clk);
        chk("to_valid_drop", {31'd0, t_m_valid}, 32'd0);
        chk("to_d_ack", {31'd0, t_d_ack}, 32'd1);
        chk("to_d_rdata", t_d_rdata, 32'd0);
        chk("to_err_set", {31'd0, t_err}, 32'd1);
        d_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("to_err_sticky", {31'd0, t_err}, 32'd1);
        chk("to_d_ack_end", {31'd0, t_d_ack}, 32'd0);

        // Reset mid-BUSY, then re-arbitration of the still-held request.
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'hC0;
        @(negedge clk);
        chk("r_busy", {31'd0, m_valid}, 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("r_valid_async", {31'd0, m_valid}, 32'd0);
        chk("r_err_async", {31'd0, t_err}, 32'd0);
        acks = 0;
        repeat (2) begin
            @(negedge clk);
            acks += int'(d_ack) + int'(i_ack);
        end
        chk("r_no_ack", acks, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("r_regrant", {31'd0, m_valid}, 32'd1);
        chk("r_regrant_addr", m_addr, 32'hC0);
        m_ready = 1'b1; m_rdata = 32'h13579BDF;
        @(negedge clk);
        chk("r_ack_after", {31'd0, d_ack}, 32'd1);
        chk("r_rdata_after", d_rdata, 32'h13579BDF);

        // Back-to-back loads with d_req held.
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; m_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("b_valid_%0d", k), {31'd0, m_valid}, 32'd1);
            chk($sformatf("b_addr_%0d", k), m_addr, 32'h300 + 32'(4 * k));
            m_rdata = 32'h1000 + 32'(k);
            @(negedge clk);
            chk($sformatf("b_ack_%0d", k), {31'd0, d_ack}, 32'd1);
            chk($sformatf("b_rdata_%0d", k), d_rdata, 32'h1000 + 32'(k));
            @(negedge clk);
            chk($sformatf("b_gap_%0d", k), {30'd0, m_valid, d_ack}, 32'd0);
            d_addr = 32'h300 + 32'(4 * (k + 1));
            if (k == 2) d_req = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MAX_WAIT, default 16, number of cycles the block waits for m_ready before timing out; legal range 1..255.
REQ-002 Clocking and reset are fixed: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 i_req  input  1  instruction-fetch read request; held high until i_ack.
REQ-006 i_addr  input  32  fetch address; stable while i_req is high.
REQ-007 i_rdata  output  32  fetch data; valid only while i_ack is high.
REQ-008 i_ack  output  1  one-cycle fetch completion pulse.
REQ-009 d_req  input  1  data request; held high until d_ack.
REQ-010 d_we  input  1  data request is a write (1) or a read (0).
REQ-011 d_addr, d_wdata  input  32 each  data address and write data; stable while d_req is high.
REQ-012 d_rdata  output  32  load data; valid only while d_ack is high.
REQ-013 d_ack  output  1  one-cycle data completion pulse.
REQ-014 m_valid, m_we  output  1 each  shared-memory request valid and write enable.
REQ-015 m_addr, m_wdata  output  32 each  shared-memory address and write data.
REQ-016 m_rdata  input  32  memory read data, sampled when m_ready is high.
REQ-017 m_ready  input  1  memory accepts or completes the current request in this cycle.
REQ-018 err  output  1  sticky timeout flag.

Function
REQ-019 The FSM SHALL have three states: IDLE, BUSY and ACK; all outputs SHALL be registered.
REQ-020 IDLE SHALL sample i_req and d_req at each rising edge; with neither high, the FSM SHALL remain in IDLE.
REQ-021 With exactly one request high, IDLE SHALL grant that requester and move to BUSY.
REQ-022 With both requests high, IDLE SHALL grant the requester that was not granted last (round-robin); the last-grant flag SHALL reset to D, so I wins the first tie.
REQ-023 On a grant, m_valid SHALL be 1 and m_addr/m_wdata/m_we SHALL be latched from the granted port; an I grant SHALL use m_we=0 and m_wdata=0.
REQ-024 m_valid, m_addr, m_wdata and m_we SHALL stay constant in BUSY until m_ready is sampled high.
REQ-025 When m_ready is sampled high in BUSY, the block SHALL capture m_rdata, clear m_valid and move to ACK.
REQ-026 In ACK, exactly the granted port's ack SHALL be 1 for one cycle with its rdata equal to the captured value (0 for a write); the FSM SHALL then return to IDLE.
REQ-027 i_rdata and d_rdata SHALL read 0 outside their ack cycle.
REQ-028 Minimum latency SHALL be: request sampled at edge N, m_valid high in cycle N+1, and ack in cycle N+2 if m_ready is high in cycle N+1.
REQ-029 A new grant SHALL be possible no earlier than 3 cycles after the previous grant.
REQ-030 A requester SHALL drop its req in the cycle after its ack; the ACK→IDLE step guarantees that a completed request is never re-granted.
REQ-031 An 8-bit wait counter SHALL clear on grant and increment on each BUSY cycle in which m_ready is low.
REQ-032 When the wait counter equals MAX_WAIT with m_ready still low, the block SHALL: drop m_valid, set err=1, and go to ACK with rdata=0.
REQ-033 err SHALL stay set until reset.
REQ-034 Requests arriving while in BUSY or ACK SHALL wait and SHALL NOT be lost.
REQ-035 m_ready high in IDLE or ACK SHALL be ignored.

Reset
REQ-036 reset low SHALL immediately force: state=IDLE, m_valid=0, m_we=0, m_addr=0, m_wdata=0, i_ack=0, d_ack=0, i_rdata=0, d_rdata=0, err=0, wait counter=0 and last-grant=D.
REQ-037 A reset mid-transaction SHALL abandon that transaction with no ack; after reset release, still-high requests SHALL be re-arbitrated from IDLE.

Verification
REQ-038 Single fetch: i_req=1, i_addr=0x100, m_ready tied 1, m_rdata=0xDEADBEEF -> m_valid with m_addr=0x100 one cycle later; i_ack=1 and i_rdata=0xDEADBEEF the next cycle.
REQ-039 Tie: i_req and d_req both high from reset -> I served first, then D (d_we=1, d_addr=0x40, d_wdata=0x12345678 seen on m_*); with both held, grants alternate I,D,I,D.
REQ-040 Wait states: m_ready low for 5 cycles after grant, then high -> m_addr, m_wdata and m_we constant all 6 cycles; exactly one ack follows.
REQ-041 Timeout: MAX_WAIT=4, m_ready held 0 -> m_valid drops after 4 wait cycles; d_ack pulses with d_rdata=0; err=1 and stays set.
REQ-042 Reset mid-BUSY: reset low while m_valid=1 -> m_valid=0 before the next clock edge; no ack; err=0.
REQ-043 Back-to-back: d_req held through 3 loads with m_ready=1 -> grants every 3 cycles and 3 d_ack pulses carrying the correct data.
